// File: rtl/ppu_pkg.sv
// Shared constants for the PPU CPU port: register offsets, CTRL bit positions,
// address-region bases, FSM encoding and the palette mirror rule.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam int CTRL_INC_BIT = 2;
  localparam int CTRL_NMI_BIT = 7;

  localparam logic [13:0] BASE_NT  = 14'h2000;
  localparam logic [13:0] BASE_PAL = 14'h3F00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  // Sprite backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
  function automatic logic [4:0] pal_alias(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

// File: rtl/ppu_cpu_port_if.sv
// CPU register-window bus plus the handshaked nametable VRAM request bus.
interface ppu_cpu_port_if;

  logic [2:0]  cpu_a;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cpu_busy;

  logic [10:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata;
  logic        vram_ack;

  modport master (
    output cpu_a, cpu_din, cpu_we, cpu_rd, vram_rdata, vram_ack,
    input  cpu_dout, cpu_busy, vram_addr, vram_wdata, vram_we, vram_re
  );

  modport slave (
    input  cpu_a, cpu_din, cpu_we, cpu_rd, vram_rdata, vram_ack,
    output cpu_dout, cpu_busy, vram_addr, vram_wdata, vram_we, vram_re
  );

endinterface

// File: rtl/ppu_palette_ram.sv
// 32x6 palette RAM: one synchronous write port, two asynchronous read ports,
// with backdrop mirroring applied on every port.
module ppu_palette_ram
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [5:0] i_wdata,
  input  logic [4:0] i_raddr_a,
  output logic [5:0] o_rdata_a,
  input  logic [4:0] i_raddr_b,
  output logic [5:0] o_rdata_b
);

  logic [5:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[pal_alias(i_waddr)] <= i_wdata;
  end

  assign o_rdata_a = r_mem[pal_alias(i_raddr_a)];
  assign o_rdata_b = r_mem[pal_alias(i_raddr_b)];

endmodule

// File: rtl/ppu_cpu_port.sv
// CPU-side register window of the PPU: CTRL/STATUS/ADDR/DATA decode, VRAM request
// handshake and palette RAM ownership.
//   state   | meaning
//   ST_IDLE | no VRAM request outstanding, DATA strobes accepted
//   ST_WR   | write request held on vram_we until vram_ack
//   ST_RD   | read request held on vram_re, ack data refills the read buffer
module ppu_cpu_port
  import ppu_pkg::*;
#(
  parameter bit MIRROR_V = 1'b1
) (
  input  logic               CLK25,
  input  logic               rst_n,
  ppu_cpu_port_if.slave      io_bus,
  input  logic               i_vblank_set,
  input  logic               i_vblank_clr,
  input  logic [4:0]         i_pal_idx,
  output logic               o_nmi,
  output logic [5:0]         o_pal_color
);

  state_t      r_state, w_state_nxt;
  logic [13:0] r_v;
  logic        r_w, r_ctrl_inc, r_ctrl_nmi, r_vblank, r_ovr;
  logic [7:0]  r_rbuf, r_dout, r_vram_wdata;
  logic [10:0] r_vram_addr;

  logic        w_wr, w_rd, w_busy;
  logic        w_data_wr, w_data_rd, w_data_ok, w_status_rd;
  logic        w_is_chr, w_is_pal, w_pal_we;
  logic [13:0] w_v_inc;
  logic [10:0] w_vram_a;
  logic [7:0]  w_status;
  logic [5:0]  w_pal_cpu;

  assign w_wr        = io_bus.cpu_we;
  assign w_rd        = io_bus.cpu_rd & ~io_bus.cpu_we;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_data_wr   = w_wr && (io_bus.cpu_a == REG_DATA);
  assign w_data_rd   = w_rd && (io_bus.cpu_a == REG_DATA);
  assign w_data_ok   = (w_data_wr | w_data_rd) & ~w_busy;
  assign w_status_rd = w_rd && (io_bus.cpu_a == REG_STATUS);

  assign w_is_chr = (r_v < BASE_NT);
  assign w_is_pal = (r_v >= BASE_PAL);
  assign w_v_inc  = r_v + (r_ctrl_inc ? 14'd32 : 14'd1);
  // Palette reads fetch v-$1000; that only flips bit 12, which the mirror drops anyway.
  assign w_vram_a = {(MIRROR_V ? r_v[10] : r_v[11]), r_v[9:0]};
  assign w_status = {r_vblank & ~i_vblank_set, 2'b00, r_ovr, 4'b0000};
  assign w_pal_we = w_data_ok & w_data_wr & w_is_pal;

  ppu_palette_ram u_pal (
    .clk       (CLK25),
    .i_we      (w_pal_we),
    .i_waddr   (r_v[4:0]),
    .i_wdata   (io_bus.cpu_din[5:0]),
    .i_raddr_a (r_v[4:0]),
    .o_rdata_a (w_pal_cpu),
    .i_raddr_b (i_pal_idx),
    .o_rdata_b (o_pal_color)
  );

  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_data_ok && !w_is_chr) begin
          if (w_data_wr && !w_is_pal) w_state_nxt = ST_WR;
          else if (w_data_rd)         w_state_nxt = ST_RD;
        end
      end
      ST_WR, ST_RD: if (io_bus.vram_ack) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io_bus.vram_we  = (r_state == ST_WR);
    io_bus.vram_re  = (r_state == ST_RD);
    io_bus.cpu_busy = w_busy;
  end

  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_v          <= '0;
      r_w          <= 1'b0;
      r_ctrl_inc   <= 1'b0;
      r_ctrl_nmi   <= 1'b0;
      r_vblank     <= 1'b0;
      r_ovr        <= 1'b0;
      r_rbuf       <= '0;
      r_dout       <= '0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
    end else begin
      if (w_wr && io_bus.cpu_a == REG_CTRL) begin
        r_ctrl_inc <= io_bus.cpu_din[CTRL_INC_BIT];
        r_ctrl_nmi <= io_bus.cpu_din[CTRL_NMI_BIT];
      end
      if (w_wr && io_bus.cpu_a == REG_ADDR) begin
        if (!r_w) r_v[13:8] <= io_bus.cpu_din[5:0];
        else      r_v[7:0]  <= io_bus.cpu_din;
        r_w <= ~r_w;
      end
      if (w_status_rd) begin
        r_dout <= w_status;
        r_ovr  <= 1'b0;
        r_w    <= 1'b0;
      end
      if ((w_data_wr | w_data_rd) && w_busy) r_ovr <= 1'b1;
      if (w_data_ok) begin
        r_v <= w_v_inc;
        if (w_data_rd) r_dout <= w_is_pal ? {2'b00, w_pal_cpu} : r_rbuf;
        if (w_data_rd && w_is_chr) r_rbuf <= '0;
        if (!w_is_chr && (w_data_rd || !w_is_pal)) r_vram_addr <= w_vram_a;
        if (w_data_wr && !w_is_chr && !w_is_pal) r_vram_wdata <= io_bus.cpu_din;
      end
      if (r_state == ST_RD && io_bus.vram_ack) r_rbuf <= io_bus.vram_rdata;
      if (i_vblank_clr)      r_vblank <= 1'b0;
      else if (i_vblank_set) r_vblank <= 1'b1;
      else if (w_status_rd)  r_vblank <= 1'b0;
    end
  end

  assign io_bus.cpu_dout   = r_dout;
  assign io_bus.vram_addr  = r_vram_addr;
  assign io_bus.vram_wdata = r_vram_wdata;
  assign o_nmi             = r_vblank & r_ctrl_nmi;

endmodule
